regfile_dump_unit: RTL and testbench

Core-side responder for the architectural-state dump used by the processor testbench and debug harness. On a single-cycle request it freezes register-file writeback, then streams all 32 integer registers (index plus data) over a valid/ready channel, one beat per cycle at full throughput. It then releases the freeze. It sits beside the register file inside `Core_Top`, sharing one spare read port.

---
 rtl/regfile_dump_unit_pkg.sv | 15 +
 rtl/regfile_dump_unit.sv | 106 ++++++++++
 tb/tb_regfile_dump_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_unit_pkg.sv
// rtl/regfile_dump_unit_pkg.sv - shared types and defaults for the register-file dump responder
package regfile_dump_unit_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int IDX_W_DEF    = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FREEZE,
    ST_SEND,
    ST_DONE
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_unit.sv
// rtl/regfile_dump_unit.sv - freezes writeback and streams every architectural register over valid/ready
module regfile_dump_unit
  import regfile_dump_unit_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_req_i,
  output logic              busy_o,
  output logic              freeze_o,
  input  logic              freeze_ack_i,
  output logic [IDX_W-1:0]  rf_rd_addr_o,
  input  logic [DATA_W-1:0] rf_rd_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  rd_addr;
  logic [IDX_W-1:0]  next_idx;
  logic              handshake;

  assign next_idx  = idx_q + IDX_W'(1);
  assign handshake = (state_q == ST_SEND) && dump_ready_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    rd_addr = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (dump_req_i) state_d = ST_FREEZE;
      end
      ST_FREEZE: begin
        if (freeze_ack_i) begin
          // x0 is hardwired, so its beat never goes through the read port
          idx_d   = '0;
          data_d  = '0;
          last_d  = (LAST_IDX == '0);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        rd_addr = idx_q;
        if (handshake) begin
          if (last_q) begin
            idx_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            // Look ahead one register so the next beat is ready on the accepting edge
            rd_addr = next_idx;
            idx_d   = next_idx;
            data_d  = rf_rd_data_i;
            last_d  = (next_idx == LAST_IDX);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign freeze_o     = (state_q == ST_FREEZE) || (state_q == ST_SEND);
  assign dump_valid_o = (state_q == ST_SEND);
  assign done_o       = (state_q == ST_DONE);
  assign rf_rd_addr_o = rd_addr;
  assign dump_idx_o   = idx_q;
  assign dump_data_o  = data_q;
  assign dump_last_o  = last_q;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// tb/tb_regfile_dump_unit.sv - directed self-checking bench for regfile_dump_unit
module tb_regfile_dump_unit;

  localparam int NR = 32;
  localparam int DW = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dump_req_i = 1'b0;
  logic          busy_o;
  logic          freeze_o;
  logic          freeze_ack_i = 1'b0;
  logic [IW-1:0] rf_rd_addr_o;
  logic [DW-1:0] rf_rd_data_i;
  logic          dump_valid_o;
  logic          dump_ready_i = 1'b1;
  logic [IW-1:0] dump_idx_o;
  logic [DW-1:0] dump_data_o;
  logic          dump_last_o;
  logic          done_o;

  regfile_dump_unit #(.NUM_REGS(NR), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .dump_req_i   (dump_req_i),
    .busy_o       (busy_o),
    .freeze_o     (freeze_o),
    .freeze_ack_i (freeze_ack_i),
    .rf_rd_addr_o (rf_rd_addr_o),
    .rf_rd_data_i (rf_rd_data_i),
    .dump_valid_o (dump_valid_o),
    .dump_ready_i (dump_ready_i),
    .dump_idx_o   (dump_idx_o),
    .dump_data_o  (dump_data_o),
    .dump_last_o  (dump_last_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rf [NR];
  assign rf_rd_data_i = rf[rf_rd_addr_o];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer: ready always high or random 50% duty, changed 1 time unit after each edge
  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    dump_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Beat monitor, sampling on the falling edge
  int            done_cnt = 0;
  logic [IW-1:0] q_idx[$];
  logic [DW-1:0] q_data[$];
  logic          q_last[$];
  logic          stall_prev = 1'b0;
  logic [IW-1:0] p_idx;
  logic [DW-1:0] p_data;
  logic          p_last;

  always @(negedge clk) begin
    if (rst) begin
      if (done_o) done_cnt++;
      if (stall_prev) begin
        check("hold_valid", dump_valid_o, 1);
        check("hold_idx", dump_idx_o, p_idx);
        check("hold_data", dump_data_o, p_data);
        check("hold_last", dump_last_o, p_last);
      end
      if (dump_valid_o && dump_ready_i) begin
        q_idx.push_back(dump_idx_o);
        q_data.push_back(dump_data_o);
        q_last.push_back(dump_last_o);
      end
      stall_prev = dump_valid_o && !dump_ready_i;
      p_idx  = dump_idx_o;
      p_data = dump_data_o;
      p_last = dump_last_o;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    q_idx.delete();
    q_data.delete();
    q_last.delete();
    done_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_freeze"}, freeze_o, 0);
    check({tag, "_addr"}, rf_rd_addr_o, 0);
    check({tag, "_valid"}, dump_valid_o, 0);
    check({tag, "_idx"}, dump_idx_o, 0);
    check({tag, "_data"}, dump_data_o, 0);
    check({tag, "_last"}, dump_last_o, 0);
    check({tag, "_done"}, done_o, 0);
  endtask

  task automatic start_dump(input int ack_delay);
    dump_req_i = 1'b1;
    tick();
    dump_req_i = 1'b0;
    check("req_freeze", freeze_o, 1);
    check("req_busy", busy_o, 1);
    for (int c = 0; c < ack_delay; c++) begin
      tick();
      check("wait_freeze", freeze_o, 1);
      check("wait_valid", dump_valid_o, 0);
      check("wait_addr", rf_rd_addr_o, 0);
    end
    freeze_ack_i = 1'b1;
    tick();
    freeze_ack_i = 1'b0;
    check("ack_valid", dump_valid_o, 1);
    check("ack_idx0", dump_idx_o, 0);
    check("ack_data0", dump_data_o, 0);
    check("ack_freeze", freeze_o, 1);
  endtask

  task automatic finish_dump(input bit req_in_done);
    bit seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("done_seen", seen, 1);
    check("done_freeze", freeze_o, 0);
    check("done_valid", dump_valid_o, 0);
    check("done_busy", busy_o, 1);
    if (req_in_done) dump_req_i = 1'b1;
    tick();
    dump_req_i = 1'b0;
    check("post_done", done_o, 0);
    check("post_busy", busy_o, 0);
  endtask

  task automatic verify_beats(input string tag);
    logic [DW-1:0] exp_data;
    check({tag, "_nbeats"}, q_idx.size(), NR);
    check({tag, "_ndone"}, done_cnt, 1);
    for (int i = 0; i < NR && i < q_idx.size(); i++) begin
      exp_data = (i == 0) ? 32'h0 : 32'hA000_0000 + 32'(i);
      check($sformatf("%s_idx%0d", tag, i), q_idx[i], i);
      check($sformatf("%s_data%0d", tag, i), q_data[i], exp_data);
      check($sformatf("%s_last%0d", tag, i), q_last[i], (i == NR - 1));
    end
  endtask

  initial begin
    rf[0] = 32'h0000_FFFF;
    for (int i = 1; i < NR; i++) rf[i] = 32'hA000_0000 + 32'(i);

    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();
    check_all_zero("idle");

    // Basic dump, ack three cycles after the request
    clear_log();
    start_dump(2);
    finish_dump(1'b0);
    verify_beats("basic");

    // Backpressure
    clear_log();
    rand_ready = 1'b1;
    start_dump(1);
    finish_dump(1'b0);
    rand_ready = 1'b0;
    verify_beats("bp");

    // Late ack
    clear_log();
    start_dump(20);
    finish_dump(1'b0);
    verify_beats("late");

    // Requests while busy, in SEND and in DONE
    clear_log();
    start_dump(0);
    tick();
    tick();
    dump_req_i = 1'b1;
    tick();
    dump_req_i = 1'b0;
    finish_dump(1'b1);
    for (int c = 0; c < 40; c++) tick();
    check("busy_req_idle", busy_o, 0);
    check("busy_req_freeze", freeze_o, 0);
    verify_beats("busyreq");

    // Reset in the middle of a dump
    clear_log();
    start_dump(0);
    begin
      bit hit = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (dump_idx_o == 5'd9) begin
          hit = 1'b1;
          break;
        end
        tick();
      end
      check("rst_reach_idx9", hit, 1);
    end
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    rst = 1'b1;
    tick();
    check("midrst_no_done", done_cnt, 0);
    check_all_zero("after_rst");
    clear_log();
    start_dump(1);
    finish_dump(1'b0);
    verify_beats("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
